rr_burst_scheduler: RTL

Shares one downstream resource between N requesters using round-robin priority. Each grant is a multi-beat burst. A requester keeps the resource until it signals last, hits MAX_BURST beats, or drops its request; priority then rotates past it. It sits alongside round_robin_arbiter, using the same req/grant one-hot convention, and adds burst ownership and valid/ready beat handshaking toward the resource.

---
 rtl/rr_burst_scheduler_pkg.sv | 24 ++
 rtl/rr_burst_scheduler_rr_pick.sv | 38 +++
 rtl/rr_burst_scheduler.sv | 100 ++++++++++
 3 files changed

// File: rtl/rr_burst_scheduler_pkg.sv
// Shared types and helpers for the round-robin burst scheduler.
// Holds the FSM state encoding and the one-hot to binary index conversion.
package sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   localparam int DFLT_N_REQ = 4;
   localparam int IDX_W      = $clog2(DFLT_N_REQ);
   localparam int MAX_IDX_W  = 4;

   // Input must be one-hot or zero; OR-ing the set positions yields the index.
   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [(1 << MAX_IDX_W)-1:0] oh);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < (1 << MAX_IDX_W); i++) begin
         if (oh[i]) idx = idx | MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_burst_scheduler_rr_pick.sv
// Rotating-priority find-first: the first set request at or after i_ptr wins.
// Purely combinational; the winner is given both one-hot and as a binary index.
module rr_pick
   import sched_pkg::*;
#(
   parameter int N_REQ = DFLT_N_REQ,
   parameter int IDX_W_P = IDX_W
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W_P-1:0] i_ptr,
   output logic o_any,
   output logic [IDX_W_P-1:0] o_idx,
   output logic [N_REQ-1:0] o_onehot
);

   logic [IDX_W_P-1:0] w_scan;
   logic [(1 << MAX_IDX_W)-1:0] w_oh_wide;

   // NOTE: every variable gets a default before the loop so no latch is inferred.
   // Scanning from the far end lets the candidate nearest i_ptr overwrite the others.
   always_comb begin
      o_any    = 1'b0;
      o_onehot = '0;
      w_scan   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_scan = IDX_W_P'((int'(i_ptr) + k) % N_REQ);
         if (i_req[w_scan]) begin
            o_any            = 1'b1;
            o_onehot         = '0;
            o_onehot[w_scan] = 1'b1;
         end
      end
   end

   assign w_oh_wide = (1 << MAX_IDX_W)'(o_onehot);
   assign o_idx     = IDX_W_P'(onehot_to_idx(w_oh_wide));

endmodule

// File: rtl/rr_burst_scheduler.sv
// Round-robin burst scheduler: one requester owns the resource per burst,
// bursts end on last, MAX_BURST beats or a dropped request, then priority rotates.
module rr_burst_scheduler
   import sched_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 4,
   parameter int BURST_W   = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] last,
   input  logic res_ready,
   output logic [N_REQ-1:0] grant,
   output logic [$clog2(N_REQ)-1:0] owner_id,
   output logic gnt_valid,
   output logic beat_fire,
   output logic busy,
   output logic [BURST_W-1:0] beat_cnt
);

   localparam int OW = $clog2(N_REQ);

   if (MAX_BURST < 1 || MAX_BURST >= (1 << BURST_W)) begin : g_bad_burst
      $error("rr_burst_scheduler: MAX_BURST must be >= 1 and fit in BURST_W bits");
   end
   if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
      $error("rr_burst_scheduler: N_REQ must be in 2..16");
   end

   state_e r_state, w_state_nxt;
   logic [N_REQ-1:0] r_grant;
   logic [OW-1:0] r_owner, r_ptr, w_ptr_nxt, w_win_idx;
   logic [N_REQ-1:0] w_win_oh;
   logic [BURST_W-1:0] r_cnt;
   logic w_any, w_busy, w_own_req, w_fire, w_end;

   rr_pick #(
      .N_REQ   (N_REQ),
      .IDX_W_P (OW)
   ) u_pick (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_any    (w_any),
      .o_idx    (w_win_idx),
      .o_onehot (w_win_oh)
   );

   assign w_busy    = (r_state == BURST);
   assign w_own_req = req[r_owner];
   assign w_fire    = w_busy & w_own_req & res_ready;
   // A dropped request ends the burst without a beat; last or the beat limit only count on a real beat.
   assign w_end     = w_busy & (~w_own_req |
                      (w_fire & (last[r_owner] | (r_cnt == BURST_W'(MAX_BURST - 1)))));
   assign w_ptr_nxt = (r_owner == OW'(N_REQ - 1)) ? '0 : r_owner + OW'(1);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any) w_state_nxt = BURST;
         BURST:   if (w_end) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_owner <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE) begin
            if (w_any) begin
               r_grant <= w_win_oh;
               r_owner <= w_win_idx;
               r_cnt   <= '0;
            end
         end else if (w_end) begin
            r_grant <= '0;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= '0;
         end else if (w_fire) begin
            r_cnt <= r_cnt + BURST_W'(1);
         end
      end
   end

   assign grant     = r_grant;
   assign owner_id  = r_owner;
   assign busy      = w_busy;
   assign gnt_valid = w_busy & w_own_req;
   assign beat_fire = w_fire;
   assign beat_cnt  = r_cnt;

endmodule
